// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers: Gray/binary conversion and the extra-bit pointer convention
// used by both the write and read sides of an async FIFO.
package fifo_pkg;

    // Pointers carry one bit more than the RAM address to tell full from empty.
    localparam int PTR_W_OFFSET = 1;

    // Width-agnostic: callers zero-extend into 32 bits and slice the result.
    localparam int CONV_W = 32;

    function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] bin);
        return bin ^ {1'b0, bin[CONV_W-1:1]};
    endfunction

    // Leading zeros above the real width leave the prefix XOR unaffected.
    function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] gray);
        logic [CONV_W-1:0] bin;
        bin[CONV_W-1] = gray[CONV_W-1];
        for (int i = CONV_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_cnt.sv
// Binary/Gray pointer pair with increment enable and synchronous reset; the Gray
// output comes straight from a flop so it is safe to synchronize into another domain.
module gray_cnt
    import fifo_pkg::*;
#(
    parameter int PW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc_i,
    output logic [PW-1:0] bin_o,
    output logic [PW-1:0] gray_o,
    output logic [PW-1:0] bin_inc_o,
    output logic [PW-1:0] gray_inc_o
);

    logic [PW-1:0]     wbin_d,  wbin_q;
    logic [PW-1:0]     wgray_d, wgray_q;
    logic [CONV_W-1:0] gray_wide_s;

    // Next pointer values; the registers below apply reset on top of these.
    always_comb begin
        wbin_d = wbin_q;
        if (inc_i) begin
            wbin_d = wbin_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            wbin_d = wbin_q;
        end
        gray_wide_s = bin2gray(CONV_W'(wbin_d));
        wgray_d     = gray_wide_s[PW-1:0];
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wbin_q  <= {PW{1'b0}};
            wgray_q <= {PW{1'b0}};
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
        end
    end

    assign bin_o      = wbin_q;
    assign gray_o     = wgray_q;
    assign bin_inc_o  = wbin_d;
    assign gray_inc_o = wgray_d;

endmodule

// File: rtl/wr_ptr_full.sv
// Async-FIFO write-side pointer and full generation.
// Optional WR_PTR_FULL_LEVEL_EN adds registered level_o and almost_full_o.
module wr_ptr_full
    import fifo_pkg::*;
#(
    parameter int AW        = 4,
    parameter int AF_MARGIN = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en_i,
    input  logic [AW+PTR_W_OFFSET-1:0] rptr_gray_sync_i,
    output logic                      full_o,
    output logic [AW-1:0]             waddr_o,
    output logic [AW+PTR_W_OFFSET-1:0] wptr_gray_o,
`ifdef WR_PTR_FULL_LEVEL_EN
    output logic [AW+PTR_W_OFFSET-1:0] level_o,
    output logic                      almost_full_o,
`endif
    output logic                      wr_ack_o
);

    localparam int PW = AW + PTR_W_OFFSET;

    logic          accept_s;
    logic [PW-1:0] wbin_s, wgray_s, wbin_inc_s, wgray_inc_s;
    logic [PW-1:0] full_cmp_s;
    logic          full_d, full_q;
    logic          wr_ack_d, wr_ack_q;

    assign accept_s = wr_en_i & ~full_q;

    gray_cnt #(.PW(PW)) u_gray_cnt (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (accept_s),
        .bin_o      (wbin_s),
        .gray_o     (wgray_s),
        .bin_inc_o  (wbin_inc_s),
        .gray_inc_o (wgray_inc_s)
    );

    // Full when the next write pointer sits exactly one lap ahead of the read pointer.
    always_comb begin
        full_cmp_s = {~rptr_gray_sync_i[PW-1:PW-2], rptr_gray_sync_i[PW-3:0]};
        full_d     = (wgray_inc_s == full_cmp_s);
        wr_ack_d   = accept_s;
    end

    // Status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q   <= 1'b0;
            wr_ack_q <= 1'b0;
        end else begin
            full_q   <= full_d;
            wr_ack_q <= wr_ack_d;
        end
    end

    assign full_o      = full_q;
    assign wr_ack_o    = wr_ack_q;
    assign waddr_o     = wbin_s[AW-1:0];
    assign wptr_gray_o = wgray_s;

`ifdef WR_PTR_FULL_LEVEL_EN
    localparam logic [PW-1:0] AF_THRESH = PW'((2 ** AW) - AF_MARGIN);

    logic [CONV_W-1:0] rbin_wide_s;
    logic [PW-1:0]     level_d, level_q;
    logic              almost_full_d, almost_full_q;

    // Occupancy seen from the write side, wrapping modulo the pointer range.
    always_comb begin
        rbin_wide_s   = gray2bin(CONV_W'(rptr_gray_sync_i));
        level_d       = wbin_inc_s - rbin_wide_s[PW-1:0];
        almost_full_d = (level_d >= AF_THRESH);
    end

    // Level registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q       <= {PW{1'b0}};
            almost_full_q <= 1'b0;
        end else begin
            level_q       <= level_d;
            almost_full_q <= almost_full_d;
        end
    end

    assign level_o       = level_q;
    assign almost_full_o = almost_full_q;
`endif

endmodule
